// File: rtl/auto_tiling_input_pkg.sv
// Shared dimensions and index types for the tiling address generators.
// Optional status outputs are enabled by defining AUTO_TILING_STATUS_EN.
package auto_tiling_input_pkg;

    localparam int LANES  = 16;
    localparam int ROWS   = 147;
    localparam int COLS   = 25;
    localparam int ADDR_W = 15;

    localparam int NCT = (COLS + LANES - 1) / LANES;
    localparam int NRT = (ROWS + LANES - 1) / LANES;

    localparam int R_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TC_W = (NCT > 1) ? $clog2(NCT) : 1;
    localparam int TR_W = (NRT > 1) ? $clog2(NRT) : 1;

    typedef logic [R_W-1:0]    r_t;
    typedef logic [TC_W-1:0]   tc_t;
    typedef logic [TR_W-1:0]   tr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam r_t  R_LAST  = r_t'(LANES - 1);
    localparam tc_t TC_LAST = tc_t'(NCT - 1);
    localparam tr_t TR_LAST = tr_t'(NRT - 1);

    // Row-major byte address, formed at full width and then truncated.
    function automatic addr_t lane_addr(int row, int col);
        return addr_t'(row * COLS + col);
    endfunction

endpackage

// File: rtl/auto_tiling_input_if.sv
// Tile-position bundle between the sequencer and the address array.
// Unaffected by AUTO_TILING_STATUS_EN.
interface auto_tiling_input_if;
    import auto_tiling_input_pkg::*;

    logic enable;
    r_t   r;
    tc_t  tc;
    tr_t  tr;

    modport master (input enable, output r, output tc, output tr);
    modport slave  (output enable, input r, input tc, input tr);

endinterface

// File: rtl/auto_tiling_input_tile_sequencer.sv
// Nested r/tc/tr wrap counter; column tiles form the inner loop.
// Unaffected by AUTO_TILING_STATUS_EN.
module tile_sequencer
    import auto_tiling_input_pkg::*;
(
    input logic            clock,
    input logic            reset,
    auto_tiling_input_if.master sq
);

    // Advance one tile row per enabled cycle, holding otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sq.r  <= '0;
            sq.tc <= '0;
            sq.tr <= '0;
        end else if (sq.enable) begin
            if (sq.r == R_LAST) begin
                sq.r <= '0;
                if (sq.tc == TC_LAST) begin
                    sq.tc <= '0;
                    if (sq.tr == TR_LAST)
                        sq.tr <= '0;
                    else
                        sq.tr <= sq.tr + 1'b1;
                end else begin
                    sq.tc <= sq.tc + 1'b1;
                end
            end else begin
                sq.r <= sq.r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/auto_tiling_input.sv
// Operand tiling address generator: one tile row of addresses per cycle.
// Define AUTO_TILING_STATUS_EN to add io_tileDone / io_allDone.
module auto_tiling_input
    import auto_tiling_input_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  io_enable,
    output addr_t io_rdAddr_0,
    output addr_t io_rdAddr_1,
    output addr_t io_rdAddr_2,
    output addr_t io_rdAddr_3,
    output addr_t io_rdAddr_4,
    output addr_t io_rdAddr_5,
    output addr_t io_rdAddr_6,
    output addr_t io_rdAddr_7,
    output addr_t io_rdAddr_8,
    output addr_t io_rdAddr_9,
    output addr_t io_rdAddr_10,
    output addr_t io_rdAddr_11,
    output addr_t io_rdAddr_12,
    output addr_t io_rdAddr_13,
    output addr_t io_rdAddr_14,
    output addr_t io_rdAddr_15,
    output logic  io_addrValid_0,
    output logic  io_addrValid_1,
    output logic  io_addrValid_2,
    output logic  io_addrValid_3,
    output logic  io_addrValid_4,
    output logic  io_addrValid_5,
    output logic  io_addrValid_6,
    output logic  io_addrValid_7,
    output logic  io_addrValid_8,
    output logic  io_addrValid_9,
    output logic  io_addrValid_10,
    output logic  io_addrValid_11,
    output logic  io_addrValid_12,
    output logic  io_addrValid_13,
    output logic  io_addrValid_14,
`ifdef AUTO_TILING_STATUS_EN
    output logic  io_addrValid_15,
    output logic  io_tileDone,
    output logic  io_allDone
`else
    output logic  io_addrValid_15
`endif
);

    auto_tiling_input_if seq_if ();

    assign seq_if.enable = io_enable;

    tile_sequencer u_seq (
        .clock (clock),
        .reset (reset),
        .sq    (seq_if.master)
    );

    int    row_idx;
    int    col_base;
    addr_t addr  [LANES];
    logic  valid [LANES];

    assign row_idx  = int'(seq_if.tr) * LANES + int'(seq_if.r);
    assign col_base = int'(seq_if.tc) * LANES;

    // Per-lane address and valid; invalid lanes are forced to zero.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            valid[j] = io_enable && (row_idx < ROWS)
                       && ((col_base + j) < COLS);
            addr[j]  = valid[j] ? lane_addr(row_idx, col_base + j)
                                : '0;
        end
    end

    assign io_rdAddr_0  = addr[0];
    assign io_rdAddr_1  = addr[1];
    assign io_rdAddr_2  = addr[2];
    assign io_rdAddr_3  = addr[3];
    assign io_rdAddr_4  = addr[4];
    assign io_rdAddr_5  = addr[5];
    assign io_rdAddr_6  = addr[6];
    assign io_rdAddr_7  = addr[7];
    assign io_rdAddr_8  = addr[8];
    assign io_rdAddr_9  = addr[9];
    assign io_rdAddr_10 = addr[10];
    assign io_rdAddr_11 = addr[11];
    assign io_rdAddr_12 = addr[12];
    assign io_rdAddr_13 = addr[13];
    assign io_rdAddr_14 = addr[14];
    assign io_rdAddr_15 = addr[15];

    assign io_addrValid_0  = valid[0];
    assign io_addrValid_1  = valid[1];
    assign io_addrValid_2  = valid[2];
    assign io_addrValid_3  = valid[3];
    assign io_addrValid_4  = valid[4];
    assign io_addrValid_5  = valid[5];
    assign io_addrValid_6  = valid[6];
    assign io_addrValid_7  = valid[7];
    assign io_addrValid_8  = valid[8];
    assign io_addrValid_9  = valid[9];
    assign io_addrValid_10 = valid[10];
    assign io_addrValid_11 = valid[11];
    assign io_addrValid_12 = valid[12];
    assign io_addrValid_13 = valid[13];
    assign io_addrValid_14 = valid[14];
    assign io_addrValid_15 = valid[15];

`ifdef AUTO_TILING_STATUS_EN
    assign io_tileDone = io_enable && !reset && (seq_if.r == R_LAST);
    assign io_allDone  = io_enable && !reset && (seq_if.r == R_LAST)
                         && (seq_if.tc == TC_LAST)
                         && (seq_if.tr == TR_LAST);
`endif

endmodule

// File: tb/tb_auto_tiling_input.sv
// Bench for auto_tiling_input: position-count model plus literal checks.
// Status outputs are checked when AUTO_TILING_STATUS_EN is defined.
`timescale 1ns/100ps
module tb_auto_tiling_input;

    localparam int L = 16;
    localparam int NROW = 147;
    localparam int NCOL = 25;
    localparam int SEQ = 320;

    logic clock = 1'b0;
    logic reset;
    logic io_enable;
    logic [14:0] rd [L];
    logic vd [L];
`ifdef AUTO_TILING_STATUS_EN
    logic io_tileDone;
    logic io_allDone;
`endif

    int errors = 0;
    int checks = 0;
    int n = 0;

    always #5 clock = ~clock;

    auto_tiling_input dut (
        .clock (clock), .reset (reset), .io_enable (io_enable),
        .io_rdAddr_0 (rd[0]),   .io_rdAddr_1 (rd[1]),
        .io_rdAddr_2 (rd[2]),   .io_rdAddr_3 (rd[3]),
        .io_rdAddr_4 (rd[4]),   .io_rdAddr_5 (rd[5]),
        .io_rdAddr_6 (rd[6]),   .io_rdAddr_7 (rd[7]),
        .io_rdAddr_8 (rd[8]),   .io_rdAddr_9 (rd[9]),
        .io_rdAddr_10 (rd[10]), .io_rdAddr_11 (rd[11]),
        .io_rdAddr_12 (rd[12]), .io_rdAddr_13 (rd[13]),
        .io_rdAddr_14 (rd[14]), .io_rdAddr_15 (rd[15]),
        .io_addrValid_0 (vd[0]),   .io_addrValid_1 (vd[1]),
        .io_addrValid_2 (vd[2]),   .io_addrValid_3 (vd[3]),
        .io_addrValid_4 (vd[4]),   .io_addrValid_5 (vd[5]),
        .io_addrValid_6 (vd[6]),   .io_addrValid_7 (vd[7]),
        .io_addrValid_8 (vd[8]),   .io_addrValid_9 (vd[9]),
        .io_addrValid_10 (vd[10]), .io_addrValid_11 (vd[11]),
        .io_addrValid_12 (vd[12]), .io_addrValid_13 (vd[13]),
        .io_addrValid_14 (vd[14]),
`ifdef AUTO_TILING_STATUS_EN
        .io_addrValid_15 (vd[15]),
        .io_tileDone (io_tileDone),
        .io_allDone (io_allDone)
`else
        .io_addrValid_15 (vd[15])
`endif
    );

    // Model: n counts enabled cycles since reset, modulo one full pass.
    always @(posedge clock or posedge reset) begin
        if (reset) n <= 0;
        else if (io_enable) n <= (n + 1) % SEQ;
    end

    // Position of enabled cycle k: tile (k/16), inner column tile.
    function automatic void expect_lane(input int k, input int j,
                                        input bit en,
                                        output int ea, output bit ev);
        int tile, row, col;
        tile = k / L;
        row  = (tile / 2) * L + (k % L);
        col  = (tile % 2) * L + j;
        ev = en && row < NROW && col < NCOL;
        ea = ev ? (row * NCOL + col) % 32768 : 0;
    endfunction

    // Per-cycle comparison of all lanes against the model.
    always @(negedge clock) begin
        int ea;
        bit ev;
        int bad;
        if (!reset) begin
            bad = -1;
            for (int j = 0; j < L; j++) begin
                expect_lane(n, j, io_enable, ea, ev);
                if (bad < 0 && (rd[j] !== 15'(ea) || vd[j] !== ev))
                    bad = j;
            end
            checks++;
            if (bad >= 0) begin
                expect_lane(n, bad, io_enable, ea, ev);
                errors++;
                $display("FAIL cycle n=%0d lane%0d: addr=%0d valid=%0b, expected addr=%0d valid=%0b",
                         n, bad, rd[bad], vd[bad], ea, ev);
            end
`ifdef AUTO_TILING_STATUS_EN
            checks++;
            if (io_tileDone !== (io_enable && (n % L) == L - 1) ||
                io_allDone !== (io_enable && n == SEQ - 1)) begin
                errors++;
                $display("FAIL status n=%0d: tileDone=%0b allDone=%0b en=%0b",
                         n, io_tileDone, io_allDone, io_enable);
            end
`endif
        end
    end

    task automatic lit(input string nm, input int lane,
                       input int ea, input bit ev);
        checks++;
        if (rd[lane] !== 15'(ea) || vd[lane] !== ev) begin
            errors++;
            $display("FAIL %s: lane%0d addr=%0d valid=%0b, expected addr=%0d valid=%0b",
                     nm, lane, rd[lane], vd[lane], ea, ev);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_to(input int target);
        int budget;
        budget = 2 * SEQ;
        io_enable = 1'b1;
        while (n != target && budget > 0) begin
            tick();
            budget--;
        end
        if (n != target) begin
            errors++;
            checks++;
            $display("FAIL run_to: n=%0d expected %0d", n, target);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        io_enable = 1'b0;
        #1;
        lit("reset_idle", 0, 0, 1'b0);
        io_enable = 1'b1;
        #1;
        lit("reset_en", 1, 1, 1'b1);
        io_enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        io_enable = 1'b1;
        #1;
        lit("first_l0", 0, 0, 1'b1);
        lit("first_l15", 15, 15, 1'b1);
        cnt = 0;
        for (int j = 0; j < L; j++) cnt += int'(vd[j]);
        checks++;
        if (cnt != 16) begin
            errors++;
            $display("FAIL first_allvalid: count=%0d expected 16", cnt);
        end
        tick();
        lit("second_l0", 0, 25, 1'b1);
        lit("second_l15", 15, 40, 1'b1);
        run_to(15);
        lit("r15_l0", 0, 375, 1'b1);
`ifdef AUTO_TILING_STATUS_EN
        checks++;
        if (io_tileDone !== 1'b1) begin
            errors++;
            $display("FAIL tileDone_r15: got %0b expected 1", io_tileDone);
        end
`endif
        tick();
        lit("tc1_l0", 0, 16, 1'b1);
        lit("tc1_l8", 8, 24, 1'b1);
        lit("tc1_l9", 9, 0, 1'b0);
        lit("tc1_l15", 15, 0, 1'b0);

        run_to(20);
        io_enable = 1'b0;
        #1;
        lit("pause_l0", 0, 0, 1'b0);
        repeat (5) tick();
        io_enable = 1'b1;
        #1;
        lit("resume_l0", 0, 116, 1'b1);

        run_to(288);
        lit("tr9_r0", 0, 3600, 1'b1);
        tick();
        lit("tr9_r1", 0, 3625, 1'b1);
        tick();
        lit("tr9_r2", 0, 3650, 1'b1);
        tick();
        lit("tr9_r3", 0, 0, 1'b0);
        run_to(319);
        lit("last", 0, 0, 1'b0);
`ifdef AUTO_TILING_STATUS_EN
        checks++;
        if (io_allDone !== 1'b1) begin
            errors++;
            $display("FAIL allDone_last: got %0b expected 1", io_allDone);
        end
`endif
        tick();
        lit("wrap_l0", 0, 0, 1'b1);

        repeat (800) begin
            io_enable = ($urandom_range(0, 9) < 7);
            tick();
        end

        run_to(53);
        #2 reset = 1'b1;
        #1;
        lit("async_l0", 0, 0, 1'b1);
        lit("async_l15", 15, 15, 1'b1);
        #0.5 reset = 1'b0;
        tick();
        lit("post_reset", 0, 25, 1'b1);

        repeat (300) begin
            io_enable = ($urandom_range(0, 3) != 0);
            tick();
        end
        io_enable = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/auto_tiling_input.md
Name: auto_tiling_input

Overview:
- Address generator that tiles a row-major operand matrix (ROWS x COLS bytes, im2col'd activations) into LANES x LANES tiles.
- Each enabled cycle it emits one tile row: LANES byte addresses plus per-lane valid flags.
- Sits in front of an external operand memory and feeds the weight-buffer load path of the systolic accelerator (input-stationary flow).
- Read data is returned combinationally outside this block; invalid lanes are zero-filled there.

Parameters:
- LANES, 16, tile width/height; number of address lanes.
- ROWS, 147, matrix row count (K dimension).
- COLS, 25, matrix column count.
- ADDR_W, 15, width of each output address.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- io_enable  input  1  advance/emit strobe.
- io_rdAddr_0 .. io_rdAddr_15  output  ADDR_W each  byte address, lane j.
- io_addrValid_0 .. io_addrValid_15  output  1 each  lane j address valid.

Behaviour:
- State registers:
  - r: row within tile, 0..LANES-1.
  - tc: column-tile index, 0..NCT-1, where NCT = ceil(COLS/LANES) = 2.
  - tr: row-tile index, 0..NRT-1, where NRT = ceil(ROWS/LANES) = 10.
- Reset: asynchronous; r = tc = tr = 0 immediately, even mid-sequence.
- Outputs are combinational from the current state and io_enable, with zero latency. The address for the current row is valid in the same cycle io_enable is high.
- For lane j:
  - row = tr*LANES + r; col = tc*LANES + j.
  - valid_j = io_enable & (row < ROWS) & (col < COLS).
  - addr_j = row*COLS + col, computed at full width then truncated to ADDR_W, when valid_j; otherwise 0.
- Outputs while io_enable = 0: all valids 0, all addresses 0.
- Sequencing, on each rising edge with io_enable = 1:
  - r increments.
  - When r = LANES-1, r wraps to 0 and tc increments.
  - When tc also = NCT-1, tc wraps to 0 and tr increments.
  - When tr also = NRT-1, all indices wrap to 0. Column tiles form the inner loop.
- io_enable = 0: state holds, so a sequence resumes where it paused.
- Rows past ROWS in the last row-tile are still stepped through with all lanes invalid. This keeps exactly LANES cycles per tile.
- No handshake beyond io_enable. The consumer samples outputs in the enabled cycle.

Optional Feature:
- Macro AUTO_TILING_STATUS_EN.
- When defined, adds two 1-bit outputs:
  - io_tileDone: high in an enabled cycle with r = LANES-1.
  - io_allDone: high in an enabled cycle with r = LANES-1, tc = NCT-1 and tr = NRT-1.
  - Both are combinational and 0 during reset.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package: LANES, ROWS, COLS, ADDR_W, derived NCT/NRT, and index widths. The weight-side generator reuses the package with its own dimensions.
- One sub-module, tile_sequencer: the r/tc/tr nested wrap counter with enable and async reset.
- The top level holds the LANES-wide combinational address/valid array.

Test Plan:
- Reset, then io_enable = 1 for the first cycle -> lane0 addr 0, lane15 addr 15, all 16 valids 1.
- Second enabled cycle -> lane0 addr 25, lane15 addr 40, all valid. 16th enabled cycle (r = 15) -> lane0 addr 375.
- 17th enabled cycle (tc = 1, r = 0) -> lanes 0..8 addr 16..24 valid; lanes 9..15 valid 0 with addr 0.
- Drop io_enable for 5 cycles mid-tile -> all valids 0; on re-enable, addresses continue from the held row, not row 0.
- Advance to tr = 9 (row 144), enabled cycles r = 0..2 -> valid rows 144..146 (lane0 addr 3600, 3625, 3650). r = 3..15 -> all lanes invalid. After the final cycle, the next enabled cycle -> lane0 addr 0 (wrap).
- Assert reset asynchronously mid-tile, between clock edges -> outputs immediately reflect r = tc = tr = 0. With AUTO_TILING_STATUS_EN, io_tileDone pulses every 16th enabled cycle and io_allDone once per 320.
